// File: rtl/if_stage_brpred.sv
// ---------------------------------------------------------------------------
// if_stage_brpred
//   Instruction-fetch stage with a small branch-history table (BHT) of 2-bit
//   saturating counters. It predicts beq/bne, redirects on mispredicts and
//   jumps from ID, and holds a redirect that arrives while the I-cache stalls.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   stall_i                    load-use stall (PC holds)
//   icache_stall_i             instruction memory not ready (PC holds)
//   instruction_i[31:0]        fetched word at PC_o
//   br_valid_i                 ID resolved a conditional branch this cycle
//   br_taken_i                 resolved outcome
//   br_mispredict_i            resolved outcome differs from its prediction
//   br_target_i[31:0]          resolved taken target
//   br_pc4_i[31:0]             PC+4 of the resolved branch
//   jump_i, jump_target_i      unconditional redirect from ID
//   PC_o, incremented_PC_o     fetch address and fetch address + 4
//   BrPre_o, PCbranch_o        predicted-taken flag and predicted target
//   flush_o                    kill the wrong-path word in IF/ID
//   br_cnt_o, miss_cnt_o       saturating resolved / mispredicted counters
//
// Handshake: there is no valid/ready pair. The stage fetches every cycle;
// stall_i and icache_stall_i are hold requests that freeze PC_o. A redirect
// is a single-cycle request. If it lands during icache_stall_i it is kept in
// a one-entry pending register until the first edge without icache_stall_i.
// ---------------------------------------------------------------------------
module if_stage_brpred #(
  parameter int IDX_BITS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        icache_stall_i,
  input  logic [31:0] instruction_i,
  input  logic        br_valid_i,
  input  logic        br_taken_i,
  input  logic        br_mispredict_i,
  input  logic [31:0] br_target_i,
  input  logic [31:0] br_pc4_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  output logic [31:0] PC_o,
  output logic [31:0] incremented_PC_o,
  output logic        BrPre_o,
  output logic [31:0] PCbranch_o,
  output logic        flush_o,
  output logic [15:0] br_cnt_o,
  output logic [15:0] miss_cnt_o
);

  localparam int ENTRIES = 1 << IDX_BITS;

  logic [31:0]         pc_q, pc_d;
  logic [1:0]          bht_q [ENTRIES];
  logic [1:0]          bht_d [ENTRIES];
  logic                pend_valid_q, pend_valid_d;
  logic [31:0]         pend_target_q, pend_target_d;
  logic [15:0]         br_cnt_q, br_cnt_d;
  logic [15:0]         miss_cnt_q, miss_cnt_d;

  logic                is_br;
  logic [31:0]         imm_ext;
  logic [31:0]         pc_plus4;
  logic [31:0]         pc_branch;
  logic [IDX_BITS-1:0] lookup_idx;
  logic [IDX_BITS-1:0] upd_idx;
  logic                br_pre;
  logic                mispred;
  logic                redir_req;
  logic [31:0]         redir_target;

  // Only the opcode and immediate fields of the fetched word matter here.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instruction_i[25:16];

  // Predecode and predicted target.
  always_comb begin
    is_br      = (instruction_i[31:26] == 6'b000100) ||
                 (instruction_i[31:26] == 6'b000101);
    imm_ext    = {{14{instruction_i[15]}}, instruction_i[15:0], 2'b00};
    pc_plus4   = pc_q + 32'd4;
    pc_branch  = pc_plus4 + imm_ext;
    lookup_idx = pc_q[IDX_BITS+1:2];
    // (br_pc4_i - 4)[IDX_BITS+1:2] equals the index field of br_pc4_i minus
    // one, modulo the table size; subtracting 4 never touches bits [1:0].
    upd_idx    = br_pc4_i[IDX_BITS+1:2] - {{(IDX_BITS-1){1'b0}}, 1'b1};
    // Lookup reads the registered table, so a same-cycle update to the same
    // entry is not visible until the next cycle.
    br_pre     = is_br & bht_q[lookup_idx][1];
  end

  // Redirect request; a mispredict outranks a jump in the same cycle.
  always_comb begin
    mispred   = br_valid_i & br_mispredict_i;
    redir_req = mispred | jump_i;
    if (mispred) begin
      redir_target = br_taken_i ? br_target_i : br_pc4_i;
    end else begin
      redir_target = jump_target_i;
    end
  end

  // Next PC.
  always_comb begin
    pc_d = pc_plus4;
    if (pend_valid_q && !icache_stall_i) begin
      pc_d = pend_target_q;
    end else if (redir_req && !icache_stall_i) begin
      pc_d = redir_target;
    end else if (stall_i || icache_stall_i) begin
      pc_d = pc_q;
    end else if (br_pre) begin
      pc_d = pc_branch;
    end
  end

  // Pending redirect: captured while the I-cache stalls, newest wins,
  // consumed on the first edge the I-cache is ready.
  always_comb begin
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    if (icache_stall_i) begin
      if (redir_req) begin
        pend_valid_d  = 1'b1;
        pend_target_d = redir_target;
      end
    end else begin
      pend_valid_d = 1'b0;
    end
  end

  // BHT update.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      bht_d[i] = bht_q[i];
    end
    if (br_valid_i) begin
      if (br_taken_i) begin
        if (bht_q[upd_idx] != 2'b11) bht_d[upd_idx] = bht_q[upd_idx] + 2'b01;
      end else begin
        if (bht_q[upd_idx] != 2'b00) bht_d[upd_idx] = bht_q[upd_idx] - 2'b01;
      end
    end
  end

  // Saturating statistics counters.
  always_comb begin
    br_cnt_d   = br_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (br_valid_i && (br_cnt_q != 16'hFFFF)) begin
      br_cnt_d = br_cnt_q + 16'd1;
    end
    if (mispred && (miss_cnt_q != 16'hFFFF)) begin
      miss_cnt_d = miss_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= 32'd0;
      pend_valid_q  <= 1'b0;
      pend_target_q <= 32'd0;
      br_cnt_q      <= 16'd0;
      miss_cnt_q    <= 16'd0;
      for (int i = 0; i < ENTRIES; i++) begin
        bht_q[i] <= 2'b01;
      end
    end else begin
      pc_q          <= pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      br_cnt_q      <= br_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
      for (int i = 0; i < ENTRIES; i++) begin
        bht_q[i] <= bht_d[i];
      end
    end
  end

  assign PC_o             = pc_q;
  assign incremented_PC_o = pc_plus4;
  assign BrPre_o          = br_pre;
  assign PCbranch_o       = pc_branch;
  assign flush_o          = redir_req | pend_valid_q;
  assign br_cnt_o         = br_cnt_q;
  assign miss_cnt_o       = miss_cnt_q;

endmodule

// File: tb/tb_if_stage_brpred.sv
module tb_if_stage_brpred;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        icache_stall_i;
  logic [31:0] instruction_i;
  logic        br_valid_i;
  logic        br_taken_i;
  logic        br_mispredict_i;
  logic [31:0] br_target_i;
  logic [31:0] br_pc4_i;
  logic        jump_i;
  logic [31:0] jump_target_i;
  logic [31:0] PC_o;
  logic [31:0] incremented_PC_o;
  logic        BrPre_o;
  logic [31:0] PCbranch_o;
  logic        flush_o;
  logic [15:0] br_cnt_o;
  logic [15:0] miss_cnt_o;

  int tests = 0;
  int fails = 0;

  if_stage_brpred #(.IDX_BITS(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .stall_i          (stall_i),
    .icache_stall_i   (icache_stall_i),
    .instruction_i    (instruction_i),
    .br_valid_i       (br_valid_i),
    .br_taken_i       (br_taken_i),
    .br_mispredict_i  (br_mispredict_i),
    .br_target_i      (br_target_i),
    .br_pc4_i         (br_pc4_i),
    .jump_i           (jump_i),
    .jump_target_i    (jump_target_i),
    .PC_o             (PC_o),
    .incremented_PC_o (incremented_PC_o),
    .BrPre_o          (BrPre_o),
    .PCbranch_o       (PCbranch_o),
    .flush_o          (flush_o),
    .br_cnt_o         (br_cnt_o),
    .miss_cnt_o       (miss_cnt_o)
  );

  // Clock / reset block.
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_br();
    br_valid_i      = 1'b0;
    br_taken_i      = 1'b0;
    br_mispredict_i = 1'b0;
    br_target_i     = 32'd0;
    br_pc4_i        = 32'd0;
    jump_i          = 1'b0;
    jump_target_i   = 32'd0;
  endtask

  initial begin
    logic [1:0] exp_bht [4];
    exp_bht = '{2'b10, 2'b11, 2'b11, 2'b11};

    rst            = 1'b1;
    stall_i        = 1'b0;
    icache_stall_i = 1'b0;
    instruction_i  = 32'd0;
    clear_br();
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_pc", PC_o, 32'h0);
    check("rst_pc4", incremented_PC_o, 32'h4);
    check("rst_br_cnt", {16'd0, br_cnt_o}, 32'd0);
    check("rst_miss_cnt", {16'd0, miss_cnt_o}, 32'd0);
    check("rst_flush", {31'd0, flush_o}, 32'd0);
    check("rst_brpre", {31'd0, BrPre_o}, 32'd0);
    check("rst_bht0", {30'd0, dut.bht_q[0]}, 32'd1);
    check("rst_bht3", {30'd0, dut.bht_q[3]}, 32'd1);

    // Free run with nops.
    tick(); check("run_pc_4", PC_o, 32'h4);
    tick(); check("run_pc_8", PC_o, 32'h8);
    tick(); check("run_pc_c", PC_o, 32'hC);
    check("run_brpre", {31'd0, BrPre_o}, 32'd0);
    check("run_flush", {31'd0, flush_o}, 32'd0);

    // Train entry 0 (branch at PC 0, br_pc4 = 4) while PC is held.
    stall_i    = 1'b1;
    br_valid_i = 1'b1;
    br_taken_i = 1'b1;
    br_pc4_i   = 32'h4;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("train_bht0_%0d", k), {30'd0, dut.bht_q[0]}, {30'd0, exp_bht[k]});
    end
    check("stall_hold_pc", PC_o, 32'hC);
    check("train_br_cnt", {16'd0, br_cnt_o}, 32'd4);
    clear_br();
    stall_i = 1'b0;
    tick();
    check("pc_10", PC_o, 32'h10);

    // beq imm 3 at PC 0x10, entry 0 strongly taken.
    instruction_i = 32'h1000_0003;
    #1;
    check("beq_brpre", {31'd0, BrPre_o}, 32'd1);
    check("beq_target", PCbranch_o, 32'h20);
    check("beq_flush", {31'd0, flush_o}, 32'd0);
    tick();
    check("pred_pc_20", PC_o, 32'h20);

    // bne with negative offset: 0x24 - 8.
    instruction_i = 32'h1400_FFFE;
    #1;
    check("bne_neg_target", PCbranch_o, 32'h1C);
    check("bne_brpre", {31'd0, BrPre_o}, 32'd1);
    // Non-branch word: no prediction even though entry is strongly taken.
    instruction_i = 32'h8C00_0003;
    #1;
    check("lw_brpre", {31'd0, BrPre_o}, 32'd0);
    check("lw_target", PCbranch_o, 32'h30);

    // Same-cycle lookup/update of entry 0: lookup sees pre-update value.
    instruction_i = 32'h1000_0003;
    br_valid_i    = 1'b1;
    br_taken_i    = 1'b0;
    br_pc4_i      = 32'h4;
    #1;
    check("same_cycle_brpre", {31'd0, BrPre_o}, 32'd1);
    instruction_i = 32'd0;
    tick();
    clear_br();
    #1;
    check("nt_pc_24", PC_o, 32'h24);
    check("nt_bht0", {30'd0, dut.bht_q[0]}, 32'd2);
    check("nt_br_cnt", {16'd0, br_cnt_o}, 32'd5);

    // Mispredict, actually not taken, br_pc4 = 0x14 (update index 0).
    br_valid_i      = 1'b1;
    br_mispredict_i = 1'b1;
    br_taken_i      = 1'b0;
    br_pc4_i        = 32'h14;
    #1;
    check("mp_nt_flush", {31'd0, flush_o}, 32'd1);
    tick();
    clear_br();
    #1;
    check("mp_nt_pc", PC_o, 32'h14);
    check("mp_nt_bht0", {30'd0, dut.bht_q[0]}, 32'd1);
    check("mp_nt_miss", {16'd0, miss_cnt_o}, 32'd1);
    check("mp_nt_br_cnt", {16'd0, br_cnt_o}, 32'd6);
    check("mp_nt_flush_off", {31'd0, flush_o}, 32'd0);

    // Taken mispredict and jump together: mispredict wins.
    br_valid_i      = 1'b1;
    br_mispredict_i = 1'b1;
    br_taken_i      = 1'b1;
    br_target_i     = 32'h200;
    br_pc4_i        = 32'h8;
    jump_i          = 1'b1;
    jump_target_i   = 32'h300;
    #1;
    check("mp_jmp_flush", {31'd0, flush_o}, 32'd1);
    tick();
    clear_br();
    #1;
    check("mp_jmp_pc", PC_o, 32'h200);
    check("mp_t_bht1", {30'd0, dut.bht_q[1]}, 32'd2);
    check("mp_t_miss", {16'd0, miss_cnt_o}, 32'd2);

    // Redirect is not blocked by stall_i.
    stall_i       = 1'b1;
    jump_i        = 1'b1;
    jump_target_i = 32'h40;
    tick();
    clear_br();
    #1;
    check("stall_jump_pc", PC_o, 32'h40);
    tick();
    check("stall_hold_40", PC_o, 32'h40);
    stall_i = 1'b0;

    // Jump during a 3-cycle I-cache stall.
    icache_stall_i = 1'b1;
    jump_i         = 1'b1;
    jump_target_i  = 32'h100;
    #1;
    check("ic_flush_1", {31'd0, flush_o}, 32'd1);
    tick();
    clear_br();
    #1;
    check("ic_pc_1", PC_o, 32'h40);
    check("ic_flush_2", {31'd0, flush_o}, 32'd1);
    tick();
    check("ic_pc_2", PC_o, 32'h40);
    check("ic_flush_3", {31'd0, flush_o}, 32'd1);
    tick();
    check("ic_pc_3", PC_o, 32'h40);
    icache_stall_i = 1'b0;
    #1;
    check("ic_pend_flush", {31'd0, flush_o}, 32'd1);
    tick();
    check("ic_pc_target", PC_o, 32'h100);
    check("ic_flush_off", {31'd0, flush_o}, 32'd0);

    // Newer redirect overwrites the pending one.
    icache_stall_i = 1'b1;
    jump_i         = 1'b1;
    jump_target_i  = 32'h500;
    tick();
    jump_target_i  = 32'h600;
    tick();
    clear_br();
    icache_stall_i = 1'b0;
    tick();
    check("overwrite_pc", PC_o, 32'h600);

    // Reset while a redirect is pending drops it.
    icache_stall_i = 1'b1;
    jump_i         = 1'b1;
    jump_target_i  = 32'h700;
    tick();
    clear_br();
    rst = 1'b1;
    tick();
    rst            = 1'b0;
    icache_stall_i = 1'b0;
    #1;
    check("rst_pend_pc", PC_o, 32'h0);
    check("rst_pend_flush", {31'd0, flush_o}, 32'd0);
    check("rst_pend_bht1", {30'd0, dut.bht_q[1]}, 32'd1);
    tick();
    check("rst_pend_pc_next", PC_o, 32'h4);

    // Branch counter saturation.
    stall_i    = 1'b1;
    br_valid_i = 1'b1;
    br_taken_i = 1'b1;
    br_pc4_i   = 32'h4;
    repeat (65534) tick();
    check("sat_fffe", {16'd0, br_cnt_o}, 32'h0000_FFFE);
    tick();
    check("sat_ffff_1", {16'd0, br_cnt_o}, 32'h0000_FFFF);
    tick();
    check("sat_ffff_2", {16'd0, br_cnt_o}, 32'h0000_FFFF);
    check("sat_miss", {16'd0, miss_cnt_o}, 32'd0);
    clear_br();
    stall_i = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
